// File: rtl/huffman_pkg.sv
// huffman_pkg: shared widths, code record and FSM states for the Huffman encoder. Rev 1.0
`default_nettype none

package huffman_pkg;
  localparam int SYM_W        = 5;
  localparam int MAX_CODE_LEN = 8;
  localparam int LEN_W        = 4;

  localparam logic [2:0] ESC_PREFIX = 3'b111;

  // bits are left-aligned: the first bit on the wire is bits[MAX_CODE_LEN-1]
  typedef struct packed {
    logic [MAX_CODE_LEN-1:0] bits;
    logic [LEN_W-1:0]        len;
  } code_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/huffman_enc_lut.sv
// huffman_enc_lut: combinational symbol -> codeword lookup; symbol 0 maps to len 0. Rev 1.0
`default_nettype none

module huffman_enc_lut
  import huffman_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output code_t            code
);

  always_comb begin
    code.bits = '0;
    code.len  = '0;
    case (sym)
      5'd0: begin
        code.bits = '0;
        code.len  = '0;
      end
      5'd1: begin
        code.bits = 8'b0000_0000;
        code.len  = 4'd1;
      end
      5'd2: begin
        code.bits = 8'b1000_0000;
        code.len  = 4'd2;
      end
      5'd3: begin
        code.bits = 8'b1100_0000;
        code.len  = 4'd3;
      end
      default: begin
        code.bits = {ESC_PREFIX, sym};
        code.len  = 4'd8;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/huffman_encoder.sv
// huffman_encoder: serial MSB-first Huffman encoder, one bit per cycle, gapless codewords.
// Define HUFFMAN_ENC_SKID_EN to add a one-entry input skid buffer. Rev 1.0
`default_nettype none

module huffman_encoder
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             err
);

  state_t                  state_q, state_d;
  logic [MAX_CODE_LEN-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;
  logic                    bit_last_q, bit_last_d;
  logic                    err_q, err_d;

  code_t lut_code;
  code_t load_code;
  logic  xfer;
  logic  legal;
  logic  load;
  logic  last_bit;

  huffman_enc_lut u_lut (
    .sym  (sym_in),
    .code (lut_code)
  );

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

`ifdef HUFFMAN_ENC_SKID_EN
  logic  skid_full_q, skid_full_d;
  code_t skid_code_q, skid_code_d;

  assign sym_ready = !skid_full_q;
`else
  assign sym_ready = (state_q == IDLE) || last_bit;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    bit_last_d  = 1'b0;
    xfer        = sym_valid && sym_ready;
    legal       = (lut_code.len != '0);
    err_d       = xfer && !legal;
    load        = 1'b0;
    load_code   = lut_code;
`ifdef HUFFMAN_ENC_SKID_EN
    skid_full_d = skid_full_q;
    skid_code_d = skid_code_q;
    // A held symbol always takes priority; sym_ready is low while it is held.
    if (last_bit && skid_full_q) begin
      load        = 1'b1;
      load_code   = skid_code_q;
      skid_full_d = 1'b0;
    end else if (xfer && legal) begin
      if ((state_q == SHIFT) && !last_bit) begin
        skid_full_d = 1'b1;
        skid_code_d = lut_code;
      end else begin
        load = 1'b1;
      end
    end
`else
    load = xfer && legal;
`endif

    if (load) begin
      state_d     = SHIFT;
      bit_valid_d = 1'b1;
      bit_out_d   = load_code.bits[MAX_CODE_LEN-1];
      bit_last_d  = (load_code.len == 4'd1);
      shreg_d     = {load_code.bits[MAX_CODE_LEN-2:0], 1'b0};
      cnt_d       = load_code.len - 4'd1;
    end else if ((state_q == SHIFT) && !last_bit) begin
      bit_valid_d = 1'b1;
      bit_out_d   = shreg_q[MAX_CODE_LEN-1];
      bit_last_d  = (cnt_q == 4'd1);
      shreg_d     = {shreg_q[MAX_CODE_LEN-2:0], 1'b0};
      cnt_d       = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef HUFFMAN_ENC_SKID_EN
      skid_full_q <= 1'b0;
      skid_code_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q  <= bit_last_d;
      err_q       <= err_d;
`ifdef HUFFMAN_ENC_SKID_EN
      skid_full_q <= skid_full_d;
      skid_code_q <= skid_code_d;
`endif
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign bit_last  = bit_last_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_huffman_encoder.sv
// tb_huffman_encoder: table-driven stimulus with a bit-level scoreboard for huffman_encoder. Rev 1.0
`default_nettype none

module tb_huffman_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sym_in = 5'd0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, bit_out, bit_valid, bit_last, err;

  huffman_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] sym;
    logic [7:0] code;
    logic [3:0] len;
  } vec_t;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  localparam vec_t VIDLE = '{sym: 5'd0,  code: 8'h00, len: 4'd0};
  localparam vec_t V0    = '{sym: 5'd0,  code: 8'h00, len: 4'd0};
  localparam vec_t V1    = '{sym: 5'd1,  code: 8'h00, len: 4'd1};
  localparam vec_t V2    = '{sym: 5'd2,  code: 8'h80, len: 4'd2};
  localparam vec_t V3    = '{sym: 5'd3,  code: 8'hC0, len: 4'd3};
  localparam vec_t V4    = '{sym: 5'd4,  code: 8'hE4, len: 4'd8};
  localparam vec_t V7    = '{sym: 5'd7,  code: 8'hE7, len: 4'd8};
  localparam vec_t V16   = '{sym: 5'd16, code: 8'hF0, len: 4'd8};
  localparam vec_t V19   = '{sym: 5'd19, code: 8'hF3, len: 4'd8};
  localparam vec_t V31   = '{sym: 5'd31, code: 8'hFF, len: 4'd8};

`ifdef HUFFMAN_ENC_SKID_EN
  localparam logic EXP_RDY_SHIFT = 1'b1;
`else
  localparam logic EXP_RDY_SHIFT = 1'b0;
`endif

  exp_bit_t sb[$];
  int       checks = 0;
  int       errors = 0;
  vec_t     tbl[10];
  logic     t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: record acceptance, advance, then check every output against the scoreboard.
  task automatic tick(input vec_t v, output logic took);
    exp_bit_t e;
    logic     exp_err;
    took    = sym_valid && sym_ready;
    exp_err = took && (v.len == 4'd0);
    if (took && (v.len != 4'd0)) begin
      for (int i = 0; i < int'(v.len); i++) begin
        e.b    = v.code[7-i];
        e.last = (i == int'(v.len) - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("err", err, exp_err);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("bit_valid", bit_valid, 1'b1);
      chk("bit_out", bit_out, e.b);
      chk("bit_last", bit_last, e.last);
    end else begin
      chk("bit_valid_idle", bit_valid, 1'b0);
      chk("bit_out_idle", bit_out, 1'b0);
      chk("bit_last_idle", bit_last, 1'b0);
    end
  endtask

  task automatic send(input vec_t v);
    logic took;
    took      = 1'b0;
    sym_in    = v.sym;
    sym_valid = 1'b1;
    for (int n = 0; n < 20 && !took; n++) tick(v, took);
    chk("accept", took, 1'b1);
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic took;
    sym_valid = 1'b0;
    repeat (n) tick(VIDLE, took);
  endtask

  initial begin
    tbl = '{V1, V2, V3, V19, V4, V31, V16, V7, V0, V1};

    repeat (2) @(negedge clk);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_bit_out", bit_out, 1'b0);
    chk("rst_bit_last", bit_last, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", sym_ready, 1'b1);
    idle(2);

    send(V1);
    idle(2);

    for (int k = 0; k < 10; k++) send(tbl[k]);
    idle(10);

    send(V2);
    send(V3);
    idle(2);

    send(V19);
    for (int k = 0; k < 7; k++) begin
      chk("rdy_shift", sym_ready, EXP_RDY_SHIFT);
      tick(VIDLE, t);
    end
    chk("rdy_last", sym_ready, 1'b1);
    idle(2);

    send(V0);
    idle(2);
    send(V1);
    idle(2);

    // Reset in the middle of a long codeword, while bit 4 is on the wire.
    send(V31);
    repeat (3) tick(VIDLE, t);
    rst = 1'b1;
    #1;
    chk("arst_bit_valid", bit_valid, 1'b0);
    chk("arst_bit_out", bit_out, 1'b0);
    chk("arst_bit_last", bit_last, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    send(V2);
    idle(3);

`ifdef HUFFMAN_ENC_SKID_EN
    sym_in    = 5'd4;
    sym_valid = 1'b1;
    tick(V4, t);
    chk("skid_acc4", t, 1'b1);
    sym_in = 5'd1;
    tick(V1, t);
    chk("skid_acc1", t, 1'b1);
    sym_valid = 1'b0;
    idle(10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
